serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder built around a single full-adder cell and a registered carry. It adds two WIDTH-bit operands one bit per clock, LSB first, feeding each cycle's carry-out back as the next cycle's carry-in. It sits around the team's one-bit full-adder stage, sequencing operand bits into it and collecting its S/Cout outputs into a parallel result. It is the area-minimal alternative to a WIDTH-cell ripple adder.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 1
- clk  input  1  sole clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request to begin an addition; sampled on the rising edge
- a  input  WIDTH  operand A; captured only on an accepted start
- b  input  WIDTH  operand B; captured only on an accepted start
- cin  input  1  initial carry-in; captured only on an accepted start
- busy  output  1  high while bits are being processed (state SHIFT)
- done  output  1  one-cycle pulse; marks that sum/cout have just been updated
- sum  output  WIDTH  registered result, (a + b + cin) mod 2^WIDTH
- cout  output  1  registered final carry, bit WIDTH of a + b + cin

## Operation
- Reset: state IDLE; busy=0, done=0, sum=0, cout=0; internal carry, operand shift registers, partial-sum register and bit counter all cleared.
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE: an edge with start=1 loads a→opA, b→opB and cin→carry. It clears the counter and moves to SHIFT.
- SHIFT: on each edge the FA cell sees inputs opA[0], opB[0] and carry.
  - Its S output is shifted into partial from the MSB end.
  - carry takes the FA Cout.
  - opA and opB shift right by 1 and the counter increments.
  - On the edge that processes bit WIDTH-1: sum takes the final partial value, cout takes the final carry, and the state moves to DONE.
- DONE: done=1 for exactly one cycle.
  - The next edge goes to IDLE if start=0.
  - If start=1 on that edge, the new operands load and the state goes straight to SHIFT (back-to-back operation).
- start is ignored while in SHIFT. Operands change freely without effect, and no queuing occurs.
- sum and cout hold their last result through IDLE and through any subsequent SHIFT. They change only on a completion edge or on reset.
- Arithmetic: unsigned, modulo 2^WIDTH, and the carry is never lost. For every operation, {cout, sum} == a + b + cin.
- The counter width is max(1, clog2(WIDTH)). WIDTH=1 is legal and gives one SHIFT cycle.

## Timing
- Let start be accepted at edge k.
  - busy is high from after edge k until edge k+WIDTH.
  - sum/cout update at edge k+WIDTH.
  - done is high from edge k+WIDTH until edge k+WIDTH+1.
- Latency is WIDTH+1 cycles from the start edge to the end of done. Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- busy and done are never high together.
- The combinational path runs only through the FA cell: register → FA → register. There is no input-to-output combinational path.
- rst mid-operation (during SHIFT or DONE): at the next edge, force the reset values of every output and internal register. The in-flight result is discarded, and no done pulse is emitted.
- rst and start high on the same edge: rst wins.

## Structure
- Shared package serial_adder_pkg contains:
  - the state enum {IDLE, SHIFT, DONE}
  - the localparam DEFAULT_WIDTH = 8
  - a counter-width function (clog2 with a floor of 1)
- One sub-module, fa_cell: purely combinational, with ports A, B, Cin, S and Cout.
  - S = A^B^Cin.
  - Cout = A&B | Cin&(A^B).
  - Instantiate it once. Keep the FSM, shift registers and counter in serial_adder.

## Test plan
- WIDTH=8, a=8'h5A, b=8'hA5, cin=0, start for 1 cycle → busy for 8 cycles, then done pulse; sum=8'hFF, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'h00, b=8'h00, cin=1 → sum=8'h01, cout=0. Check that the first result holds until the second done.
- Start accepted with a=8'h12, b=8'h34. During SHIFT, pulse start with a=8'hFF, b=8'hFF → ignored. Result is sum=8'h46, cout=0, with exactly one done pulse.
- Back-to-back: start held high through DONE with a=8'h80, b=8'h80, cin=1 → sum=8'h01, cout=1 every WIDTH+1 cycles with no IDLE cycle.
- Reset at cycle 4 of SHIFT → next cycle busy=0, done=0, sum=0, cout=0, and no done pulse follows. A fresh start then computes 8'h0F+8'h01=8'h10 correctly.
- WIDTH=1 build: a=1, b=1, cin=1 → done 2 cycles after start; sum=1, cout=1. Exhaustive 8-vector sweep matches fa_cell truth table.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width; a single-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder stage, purely combinational.
module fa_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one fa_cell, registered carry, LSB-first operand shifting.
// state | meaning
// IDLE  | waiting for start; last result held on sum/cout
// SHIFT | one operand bit pair added per cycle
// DONE  | result valid, done pulse; start here chains straight into SHIFT
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s, fa_cout;

  fa_cell u_fa (
    .A   (opa_q[0]),
    .B   (opb_q[0]),
    .Cin (carry_q),
    .S   (fa_s),
    .Cout(fa_cout)
  );

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    partial_d = partial_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Shift-in from the MSB end so bit i lands at position i after WIDTH steps.
        partial_d = (partial_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d   = fa_cout;
        opa_d     = opa_q >> 1;
        opb_d     = opb_q >> 1;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = partial_d;
          cout_d  = fa_cout;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      partial_q <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      partial_q <= partial_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed + random ops, WIDTH=1 sweep.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, cin, busy, done, cout;
  logic [W-1:0] a, b, sum;
  logic         start1, cin1, busy1, done1, cout1;
  logic [0:0]   a1, b1, sum1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) u8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned addition widened by one bit.
  function automatic logic [W:0] model8(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic run8(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                      input bit poke, input bit hold_chk, input logic [W:0] held);
    logic [W:0] exp;
    int cyc;
    int pulses;
    exp   = model8(xa, xb, xc);
    a     = xa;
    b     = xb;
    cin   = xc;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    cyc = 0;
    while (!done && cyc < 4 * W) begin
      if (poke && cyc == 2) begin
        a     = '1;
        b     = '1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (hold_chk && cyc == W / 2) check("result_held", {cout, sum}, held);
      step();
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, W);
    check("busy_low_at_done", busy, 0);
    check("sum", sum, exp[W-1:0]);
    check("cout", cout, exp[W]);
    pulses = 0;
    repeat (W + 2) begin
      step();
      if (done) pulses++;
    end
    check("single_done", pulses, 0);
  endtask

  task automatic run1(input logic x, input logic y, input logic c);
    logic [1:0] exp;
    exp    = {1'b0, x} + {1'b0, y} + {1'b0, c};
    a1     = x;
    b1     = y;
    cin1   = c;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("w1_busy", busy1, 1);
    step();
    check("w1_done", done1, 1);
    check("w1_result", {cout1, sum1}, exp);
    step();
    check("w1_done_drop", done1, 0);
  endtask

  initial begin
    logic [W:0] exp;
    int cyc;
    int pulses;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    step();
    step();
    check("reset_outputs", {busy, done, cout, sum}, 0);
    check("reset_outputs_w1", {busy1, done1, cout1, sum1}, 0);
    rst = 1'b0;
    step();

    run8(8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0, '0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, '0);
    run8(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 9'h100);
    run8(8'h12, 8'h34, 1'b0, 1'b1, 1'b0, '0);

    // Back-to-back: start held high through DONE
    a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
    exp = model8(8'h80, 8'h80, 1'b1);
    step();
    for (int r = 0; r < 3; r++) begin
      cyc = 0;
      while (!done && cyc < 4 * W) begin
        step();
        cyc++;
      end
      check("b2b_latency", cyc, W);
      check("b2b_result", {cout, sum}, exp);
      if (r == 2) start = 1'b0;
      step();
      check("b2b_no_idle", busy, (r < 2) ? 1 : 0);
    end
    step();

    // Reset during SHIFT discards the operation
    a = 8'h37; b = 8'h22; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midop_reset", {busy, done, cout, sum}, 0);
    pulses = 0;
    repeat (2 * W) begin
      step();
      if (done || busy) pulses++;
    end
    check("no_done_after_reset", pulses, 0);
    run8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, '0);

    // rst and start on the same edge
    rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
    step();
    rst = 1'b0; start = 1'b0;
    step();
    check("rst_beats_start", busy, 0);

    repeat (20) run8(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0, '0);

    for (int v = 0; v < 8; v++) run1(v[2], v[1], v[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
